// File: rtl/guitar_pkg.sv
// Shared types and constants for the guitar input conditioner.
// Strum FSM states, default parameters, hit counter sizing and fret index helper.
package guitar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } strum_state_t;

  localparam int DEF_NUM_PLAYERS     = 2;
  localparam int DEF_NUM_BUTTONS     = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_CNT_W           = 18;
  localparam int DEF_REPEAT_CYCLES   = 5000000;

  localparam int              HIT_W   = 8;
  localparam logic [HIT_W-1:0] HIT_MAX = 8'd255;

  function automatic int btn_idx(input int p, input int b, input int nb);
    return p * nb + b;
  endfunction

endpackage

// File: rtl/guitar_input_ctrl_debounce_cell.sv
// debounce_cell: 2-FF synchroniser plus counter debounce for one raw line.
// o_stable is in the raw line's polarity; RESET_VAL is its released level.
module debounce_cell
  import guitar_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = DEF_CNT_W,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 1) || (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cfg
    $error("debounce_cell: DEBOUNCE_CYCLES must be >= 1 and below 2**CNT_W");
  end

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= RESET_VAL;
      r_sync2  <= RESET_VAL;
      r_stable <= RESET_VAL;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM_CNT) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/guitar_input_ctrl.sv
// guitar_input_ctrl: debounced fret/strum inputs, per-player strum FSM, note pulses, hit counters.
// Optional autorepeat while the strum is held: define GUITAR_AUTOREPEAT_EN.
module guitar_input_ctrl
  import guitar_pkg::*;
#(
  parameter int NUM_PLAYERS     = DEF_NUM_PLAYERS,
  parameter int NUM_BUTTONS     = DEF_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_n,
  input  logic [NUM_PLAYERS-1:0]       strum,
  input  logic [NUM_PLAYERS-1:0]       hit_clear,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] guitar_in,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] note_pulse,
  output logic [NUM_PLAYERS*HIT_W-1:0] hit_count
);

  localparam int NF = NUM_PLAYERS * NUM_BUTTONS;

  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("guitar_input_ctrl: REPEAT_CYCLES must be >= 1");
  end

  logic [NF-1:0]          w_fret_stable_n;
  logic [NF-1:0]          w_fret_stable;
  logic [NUM_PLAYERS-1:0] w_strum_stable;

  strum_state_t           r_state     [NUM_PLAYERS];
  logic [NUM_BUTTONS-1:0] r_note_pulse[NUM_PLAYERS];
  logic [NUM_BUTTONS-1:0] r_guitar_in [NUM_PLAYERS];
  logic [HIT_W-1:0]       r_hit_count [NUM_PLAYERS];

`ifdef GUITAR_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep_cnt [NUM_PLAYERS];
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
      localparam int IDX = btn_idx(p, b, NUM_BUTTONS);
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .RESET_VAL      (1'b1)
      ) u_fret (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_n[IDX]),
        .o_stable(w_fret_stable_n[IDX])
      );
    end

    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      (1'b0)
    ) u_strum (
      .clock   (clock),
      .reset   (reset),
      .i_raw   (strum[p]),
      .o_stable(w_strum_stable[p])
    );

    logic [NUM_BUTTONS-1:0] w_fret;
    logic                   w_emit;
    assign w_fret = w_fret_stable[p*NUM_BUTTONS +: NUM_BUTTONS];

    // w_emit marks the edge on which a note pattern is launched
    always_comb begin
      w_emit = 1'b0;
      case (r_state[p])
        ST_IDLE:   w_emit = w_strum_stable[p];
`ifdef GUITAR_AUTOREPEAT_EN
        ST_HELD,
        ST_REPEAT: w_emit = w_strum_stable[p] && (r_rep_cnt[p] == '0);
`endif
        default:   w_emit = 1'b0;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state[p]      <= ST_IDLE;
        r_note_pulse[p] <= '0;
        r_guitar_in[p]  <= '0;
        r_hit_count[p]  <= '0;
`ifdef GUITAR_AUTOREPEAT_EN
        r_rep_cnt[p]    <= '0;
`endif
      end else begin
        r_guitar_in[p]  <= w_fret & {NUM_BUTTONS{w_strum_stable[p]}};
        r_note_pulse[p] <= w_emit ? w_fret : '0;

        if (hit_clear[p]) begin
          r_hit_count[p] <= '0;
        end else if (w_emit && (|w_fret) && (r_hit_count[p] != HIT_MAX)) begin
          r_hit_count[p] <= r_hit_count[p] + 1'b1;
        end

        case (r_state[p])
          ST_IDLE: begin
            if (w_strum_stable[p]) begin
              r_state[p] <= ST_HELD;
`ifdef GUITAR_AUTOREPEAT_EN
              r_rep_cnt[p] <= REP_RELOAD;
`endif
            end
          end
`ifdef GUITAR_AUTOREPEAT_EN
          ST_HELD, ST_REPEAT: begin
            if (!w_strum_stable[p]) begin
              r_state[p]   <= ST_IDLE;
              r_rep_cnt[p] <= '0;
            end else if (r_rep_cnt[p] == '0) begin
              r_state[p]   <= ST_REPEAT;
              r_rep_cnt[p] <= REP_RELOAD;
            end else begin
              r_rep_cnt[p] <= r_rep_cnt[p] - 1'b1;
            end
          end
`else
          ST_HELD: begin
            if (!w_strum_stable[p]) r_state[p] <= ST_IDLE;
          end
`endif
          default: r_state[p] <= ST_IDLE;
        endcase
      end
    end

    assign guitar_in [p*NUM_BUTTONS +: NUM_BUTTONS] = r_guitar_in[p];
    assign note_pulse[p*NUM_BUTTONS +: NUM_BUTTONS] = r_note_pulse[p];
    assign hit_count [p*HIT_W +: HIT_W]             = r_hit_count[p];
  end

  assign w_fret_stable = ~w_fret_stable_n;

endmodule
